// File: rtl/crypto_regfile_pkg.sv
// -----------------------------------------------------------------------------
// crypto_regfile_pkg
// Shared definitions for the Avalon crypto register file:
//   state_e  - launch/busy/capture FSM encoding
//   *_B      - bit positions inside the STATUS and CTRL registers
// -----------------------------------------------------------------------------
package crypto_regfile_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LAUNCH  = 2'd1,
      BUSY    = 2'd2,
      CAPTURE = 2'd3
   } state_e;

   // STATUS register bits
   localparam int DONE_B  = 0;
   localparam int BUSY_B  = 1;
   localparam int ERR_B   = 2;

   // CTRL register bits
   localparam int START_B = 0;
   localparam int IE_B    = 1;

endpackage

// File: rtl/avalon_crypto_regfile_be_reg.sv
// -----------------------------------------------------------------------------
// be_reg
// DATA_W-bit register with byte-lane write enables.
//   clk_i, rst_i : clock, asynchronous active-high reset (clears to 0)
//   we_i         : write enable (already qualified by address and lockout)
//   be_i         : byte enables, one per 8-bit lane
//   d_i          : write data
//   q_o          : register contents
// -----------------------------------------------------------------------------
module be_reg #(
   parameter int DATA_W = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  we_i,
   input  logic [DATA_W/8-1:0]   be_i,
   input  logic [DATA_W-1:0]     d_i,
   output logic [DATA_W-1:0]     q_o
);

   logic [DATA_W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      for (int b = 0; b < DATA_W/8; b++) begin
         if (we_i && be_i[b]) q_d[8*b +: 8] = d_i[8*b +: 8];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) q_q <= '0;
      else       q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/avalon_crypto_regfile.sv
// -----------------------------------------------------------------------------
// avalon_crypto_regfile
// Avalon-MM slave register file in front of a crypto coprocessor core.
// Word map: key[0..KEY_WORDS-1], msg-in, msg-out (RO), CTRL, STATUS.
// Ports:
//   clk_clk, reset_reset        : clock, asynchronous active-high reset
//   avs_*                       : Avalon-MM slave, read latency 1
//   core_start                  : one-cycle launch pulse to the core
//   core_key, core_msg          : operand registers, word 0 in the LSBs
//   core_done, core_result      : completion and result from the core
//   export_data                 : key word EXPORT_IDX (hex display)
//   irq                         : only with CRYPTO_REGFILE_IRQ_EN defined,
//                                 registered DONE & IE
// -----------------------------------------------------------------------------
module avalon_crypto_regfile
   import crypto_regfile_pkg::*;
#(
   parameter  int DATA_W     = 32,
   parameter  int KEY_WORDS  = 4,
   parameter  int MSG_WORDS  = 4,
   parameter  int EXPORT_IDX = 0,
   localparam int CTRL_A     = KEY_WORDS + 2*MSG_WORDS,
   localparam int STAT_A     = CTRL_A + 1,
   localparam int ADDR_W     = $clog2(STAT_A + 1)
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset,
   input  logic                          avs_chipselect,
   input  logic                          avs_read,
   input  logic                          avs_write,
   input  logic [ADDR_W-1:0]             avs_address,
   input  logic [DATA_W/8-1:0]           avs_byteenable,
   input  logic [DATA_W-1:0]             avs_writedata,
   output logic [DATA_W-1:0]             avs_readdata,
   output logic                          core_start,
   output logic [KEY_WORDS*DATA_W-1:0]   core_key,
   output logic [MSG_WORDS*DATA_W-1:0]   core_msg,
   input  logic                          core_done,
   input  logic [MSG_WORDS*DATA_W-1:0]   core_result,
`ifdef CRYPTO_REGFILE_IRQ_EN
   output logic                          irq,
`endif
   output logic [DATA_W-1:0]             export_data
);

   state_e                          state_q, state_d;
   logic                            done_q, done_d, err_q, err_d;
   logic [KEY_WORDS-1:0][DATA_W-1:0] key_q;
   logic [MSG_WORDS-1:0][DATA_W-1:0] min_q;
   logic [MSG_WORDS-1:0][DATA_W-1:0] mout_q;
   logic [DATA_W-1:0]               rdata_q, rdata_d;
   logic                            wr, rd, busy, ctrl_wr, stat_wr, start_req;
`ifdef CRYPTO_REGFILE_IRQ_EN
   logic                            ie_q, irq_q;
`endif

   assign wr        = avs_chipselect & avs_write;
   assign rd        = avs_chipselect & avs_read;
   assign busy      = (state_q != IDLE);
   // CTRL/STATUS bits all live in byte lane 0
   assign ctrl_wr   = wr && (avs_address == ADDR_W'(CTRL_A)) && avs_byteenable[0];
   assign stat_wr   = wr && (avs_address == ADDR_W'(STAT_A)) && avs_byteenable[0];
   assign start_req = ctrl_wr && avs_writedata[START_B];

   // Operand registers; writes are dropped while a run is in flight so the
   // core sees stable key/message values.
   for (genvar k = 0; k < KEY_WORDS; k++) begin : g_key
      be_reg #(.DATA_W(DATA_W)) u_reg (
         .clk_i (clk_clk),
         .rst_i (reset_reset),
         .we_i  (wr && !busy && (avs_address == ADDR_W'(k))),
         .be_i  (avs_byteenable),
         .d_i   (avs_writedata),
         .q_o   (key_q[k])
      );
   end

   for (genvar m = 0; m < MSG_WORDS; m++) begin : g_min
      be_reg #(.DATA_W(DATA_W)) u_reg (
         .clk_i (clk_clk),
         .rst_i (reset_reset),
         .we_i  (wr && !busy && (avs_address == ADDR_W'(KEY_WORDS + m))),
         .be_i  (avs_byteenable),
         .d_i   (avs_writedata),
         .q_o   (min_q[m])
      );
   end

   always_comb begin
      state_d = state_q;
      done_d  = done_q;
      err_d   = err_q;
      case (state_q)
         IDLE:    if (start_req) state_d = LAUNCH;
         LAUNCH:  state_d = BUSY;
         BUSY:    if (core_done) state_d = CAPTURE;
         CAPTURE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // clears first, sets last: a set in the same cycle wins over W1C
      if (stat_wr && avs_writedata[DONE_B]) done_d = 1'b0;
      if (stat_wr && avs_writedata[ERR_B])  err_d  = 1'b0;
      if (start_req && !busy)               done_d = 1'b0;
      if (start_req && busy)                err_d  = 1'b1;
      if (state_q == CAPTURE)               done_d = 1'b1;
   end

   always_comb begin
      rdata_d = '0;
      for (int i = 0; i < KEY_WORDS; i++)
         if (avs_address == ADDR_W'(i)) rdata_d = key_q[i];
      for (int i = 0; i < MSG_WORDS; i++) begin
         if (avs_address == ADDR_W'(KEY_WORDS + i))             rdata_d = min_q[i];
         if (avs_address == ADDR_W'(KEY_WORDS + MSG_WORDS + i)) rdata_d = mout_q[i];
      end
      if (avs_address == ADDR_W'(STAT_A)) begin
         rdata_d[DONE_B] = done_q;
         rdata_d[BUSY_B] = busy;
         rdata_d[ERR_B]  = err_q;
      end
`ifdef CRYPTO_REGFILE_IRQ_EN
      if (avs_address == ADDR_W'(CTRL_A)) rdata_d[IE_B] = ie_q;
`endif
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         mout_q  <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         err_q   <= err_d;
         if (rd) rdata_q <= rdata_d;
         // Latch the result on the cycle core_done is sampled: the result is
         // only guaranteed while core_done is high, and core_done may be a
         // single-cycle pulse. DONE follows in the CAPTURE cycle.
         if (state_q == BUSY && core_done) mout_q <= core_result;
      end
   end

`ifdef CRYPTO_REGFILE_IRQ_EN
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         ie_q  <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         if (ctrl_wr) ie_q <= avs_writedata[IE_B];
         irq_q <= done_q & ie_q;
      end
   end
   assign irq = irq_q;
`endif

   assign avs_readdata = rdata_q;
   assign core_start   = (state_q == LAUNCH);
   assign core_key     = key_q;
   assign core_msg     = min_q;
   assign export_data  = key_q[EXPORT_IDX];

endmodule

// File: tb/tb_avalon_crypto_regfile.sv
// -----------------------------------------------------------------------------
// tb_avalon_crypto_regfile
// Scoreboarded bench for avalon_crypto_regfile at default parameters
// (addresses: key 0-3, msg-in 4-7, msg-out 8-11, CTRL 12, STATUS 13).
// Build with CRYPTO_REGFILE_IRQ_EN defined to also cover the irq output.
// -----------------------------------------------------------------------------
module tb_avalon_crypto_regfile;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          avs_chipselect, avs_read, avs_write;
   logic [3:0]    avs_address;
   logic [3:0]    avs_byteenable;
   logic [31:0]   avs_writedata, avs_readdata;
   logic          core_start, core_done;
   logic [127:0]  core_key, core_msg, core_result;
   logic [31:0]   export_data;
`ifdef CRYPTO_REGFILE_IRQ_EN
   logic          irq;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } rd_exp_t;
   rd_exp_t sb[$];
   logic    rd_seen = 1'b0;

   logic [127:0] ek, em;

   always #5 clk = ~clk;

   avalon_crypto_regfile dut (
      .clk_clk        (clk),
      .reset_reset    (rst),
      .avs_chipselect (avs_chipselect),
      .avs_read       (avs_read),
      .avs_write      (avs_write),
      .avs_address    (avs_address),
      .avs_byteenable (avs_byteenable),
      .avs_writedata  (avs_writedata),
      .avs_readdata   (avs_readdata),
      .core_start     (core_start),
      .core_key       (core_key),
      .core_msg       (core_msg),
      .core_done      (core_done),
      .core_result    (core_result),
`ifdef CRYPTO_REGFILE_IRQ_EN
      .irq            (irq),
`endif
      .export_data    (export_data)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // read completions: data is registered on the edge that samples the read
   always @(posedge clk) rd_seen <= avs_chipselect && avs_read;

   always @(negedge clk) begin
      rd_exp_t e;
      if (rd_seen) begin
         if (sb.size() == 0) chk("sb_underflow", 1, 0);
         else begin
            e = sb.pop_front();
            chk(e.tag, avs_readdata, e.exp);
         end
      end
   end

   // both bus tasks are entered at a negedge and return at the next one
   task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
      avs_chipselect = 1'b1; avs_write = 1'b1;
      avs_address = a; avs_writedata = d; avs_byteenable = be;
      @(negedge clk);
      avs_chipselect = 1'b0; avs_write = 1'b0; avs_byteenable = '0;
   endtask

   task automatic bus_rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
      rd_exp_t e;
      e.tag = tag; e.exp = exp;
      sb.push_back(e);
      avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = a;
      @(negedge clk);
      avs_chipselect = 1'b0; avs_read = 1'b0;
   endtask

   initial begin
      avs_chipselect = 0; avs_read = 0; avs_write = 0;
      avs_address = '0; avs_byteenable = '0; avs_writedata = '0;
      core_done = 0; core_result = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // ---- reset state
      chk("rst_start", core_start, 0);
      chk("rst_export", export_data, 0);
      bus_rd(4'd0,  32'h0, "rst_key0");
      bus_rd(4'd5,  32'h0, "rst_min1");
      bus_rd(4'd9,  32'h0, "rst_mout1");
      bus_rd(4'd13, 32'h0, "rst_stat");

      // ---- byte enables
      bus_wr(4'd1, 32'hAABBCCDD, 4'b0101);
      bus_rd(4'd1, 32'h00BB00DD, "be_key1");
      chk("be_export", export_data, 0);
      bus_wr(4'd1, 32'h11223344, 4'b1010);
      bus_rd(4'd1, 32'h11BB33DD, "be_merge");

      // ---- unmapped and CTRL readback
      bus_wr(4'd15, 32'hDEADBEEF);
      bus_rd(4'd15, 32'h0, "unmapped15");
      bus_rd(4'd14, 32'h0, "unmapped14");
      bus_wr(4'd12, 32'h2);
`ifdef CRYPTO_REGFILE_IRQ_EN
      bus_rd(4'd12, 32'h2, "ctrl_ie");
`else
      bus_rd(4'd12, 32'h0, "ctrl_rd0");
`endif
      bus_rd(4'd13, 32'h0, "ctrl_nostart");

      // ---- load operands
      for (int k = 0; k < 4; k++) begin
         bus_wr(4'(k), 32'hC0DE0000 + k);
         ek[32*k +: 32] = 32'hC0DE0000 + k;
      end
      for (int m = 0; m < 4; m++) begin
         bus_wr(4'(4 + m), 32'h5A5A0000 + m);
         em[32*m +: 32] = 32'h5A5A0000 + m;
      end
      chk("load_key", core_key, ek);
      chk("load_msg", core_msg, em);
      chk("load_export", export_data, 32'hC0DE0000);

      // ---- full run
      bus_wr(4'd12, 32'h1);
      chk("run_start_hi", core_start, 1);
      @(negedge clk);
      chk("run_start_lo", core_start, 0);
      bus_rd(4'd13, 32'h2, "run_busy");
      repeat (8) @(negedge clk);
      core_result = {32'h44, 32'h33, 32'h22, 32'h11223344};
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      repeat (3) @(negedge clk);
      bus_rd(4'd8,  32'h11223344, "run_mout0");
      bus_rd(4'd11, 32'h44, "run_mout3");
      bus_rd(4'd13, 32'h1, "run_stat");

      // ---- lockout and ERR
      bus_wr(4'd12, 32'h1);
      bus_wr(4'd4, 32'hFFFFFFFF);
      bus_wr(4'd12, 32'h1);
      bus_rd(4'd13, 32'h6, "lock_stat");
      bus_rd(4'd4, 32'h5A5A0000, "lock_min0");
      chk("lock_core_msg", core_msg, em);
      bus_wr(4'd13, 32'h4);
      bus_rd(4'd13, 32'h2, "err_w1c");
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      repeat (2) @(negedge clk);
      bus_rd(4'd13, 32'h1, "lock_done");
      bus_wr(4'd13, 32'h1);
      bus_rd(4'd13, 32'h0, "done_w1c");

      // ---- minimum latency with DONE W1C colliding with CAPTURE
      bus_wr(4'd12, 32'h1);          // LAUNCH
      chk("col_start", core_start, 1);
      @(negedge clk);                // BUSY
      core_done = 1'b1;
      bus_rd(4'd13, 32'h2, "col_busy");
      core_done = 1'b0;              // now in CAPTURE
      bus_wr(4'd13, 32'h1);
      bus_rd(4'd13, 32'h1, "col_done_wins");

`ifdef CRYPTO_REGFILE_IRQ_EN
      // ---- interrupt
      bus_wr(4'd12, 32'h3);
      @(negedge clk);
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      @(negedge clk);
      chk("irq_lag", irq, 0);
      @(negedge clk);
      chk("irq_hi", irq, 1);
      bus_wr(4'd13, 32'h1);
      chk("irq_hold", irq, 1);
      @(negedge clk);
      chk("irq_lo", irq, 0);
`endif

      // ---- reset mid-run
      bus_wr(4'd12, 32'h1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rrst_start", core_start, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rrst_key", core_key, 0);
      chk("rrst_export", export_data, 0);
      bus_rd(4'd13, 32'h0, "rrst_stat");
      bus_rd(4'd4,  32'h0, "rrst_min0");
      bus_rd(4'd8,  32'h0, "rrst_mout0");
      repeat (5) @(negedge clk);
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      repeat (2) @(negedge clk);
      bus_rd(4'd13, 32'h0, "rrst_late_done");
      bus_rd(4'd8,  32'h0, "rrst_late_mout");

      repeat (2) @(negedge clk);
      chk("sb_drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
